// File: rtl/decoder_controller.sv
// Sequencing FSM for the 24-round decryption datapath: launches the inverse
// step units RC, RE, PE, RO, CP per round with a count-down round index and a per-step watchdog.
module decoder_controller #(
  parameter int ROUNDS  = 24,
  parameter int ITER_W  = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              finish,
  output logic              busy,
  output logic              error,
  output logic              RC_start,
  output logic              RE_start,
  output logic              PE_start,
  output logic              RO_start,
  output logic              CP_start,
  input  logic              RC_finish,
  input  logic              RE_finish,
  input  logic              PE_finish,
  input  logic              RO_finish,
  input  logic              CP_finish,
  output logic [ITER_W-1:0] iteration
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, INIT,
    RC_START, RC_CAL, RE_START, RE_CAL, PE_START, PE_CAL,
    RO_START, RO_CAL, CP_START, CP_CAL,
    IT_CHECK, DONE
  } state_t;

  state_t            state, state_d;
  logic [ITER_W-1:0] iter_d;
  logic [WD_W-1:0]   wd, wd_d;
  logic              error_d;
  logic              cal_fin;
  state_t            cal_next;

  // Only the finish of the step currently being waited on is ever looked at.
  always_comb begin
    cal_fin  = 1'b0;
    cal_next = IDLE;
    case (state)
      RC_CAL: begin cal_fin = RC_finish; cal_next = RE_START; end
      RE_CAL: begin cal_fin = RE_finish; cal_next = PE_START; end
      PE_CAL: begin cal_fin = PE_finish; cal_next = RO_START; end
      RO_CAL: begin cal_fin = RO_finish; cal_next = CP_START; end
      CP_CAL: begin cal_fin = CP_finish; cal_next = IT_CHECK; end
      default: ;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state;
    iter_d  = iteration;
    wd_d    = wd;
    error_d = error;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          error_d = 1'b0;
        end
      end
      INIT: begin
        iter_d  = ITER_W'(ROUNDS - 1);
        state_d = RC_START;
      end
      RC_START: begin wd_d = '0; state_d = RC_CAL; end
      RE_START: begin wd_d = '0; state_d = RE_CAL; end
      PE_START: begin wd_d = '0; state_d = PE_CAL; end
      RO_START: begin wd_d = '0; state_d = RO_CAL; end
      CP_START: begin wd_d = '0; state_d = CP_CAL; end
      RC_CAL, RE_CAL, PE_CAL, RO_CAL, CP_CAL: begin
        // A finish on the last allowed cycle still wins over the abort.
        if (cal_fin) begin
          state_d = cal_next;
        end else if (wd == WD_MAX) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd + 1'b1;
        end
      end
      IT_CHECK: begin
        if (iteration == '0) begin
          state_d = DONE;
        end else begin
          iter_d  = iteration - 1'b1;
          state_d = RC_START;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      iteration <= '0;
      wd        <= '0;
      error     <= 1'b0;
    end else begin
      state     <= state_d;
      iteration <= iter_d;
      wd        <= wd_d;
      error     <= error_d;
    end
  end

  assign RC_start = (state == RC_START);
  assign RE_start = (state == RE_START);
  assign PE_start = (state == PE_START);
  assign RO_start = (state == RO_START);
  assign CP_start = (state == CP_START);
  assign finish   = (state == DONE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_decoder_controller.sv
// Self-checking bench for decoder_controller: a cycle-level schedule model built
// from the round/step rules drives the step finishes and predicts every output cycle.
module tb_decoder_controller;

  localparam int ROUNDS  = 24;
  localparam int ITER_W  = 5;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [4:0]        fin = '0;   // {CP, RO, PE, RE, RC}
  logic              finish, busy, error;
  logic              RC_start, RE_start, PE_start, RO_start, CP_start;
  logic [ITER_W-1:0] iteration;
  logic [4:0]        starts;

  always #5 clk = ~clk;

  decoder_controller #(.ROUNDS(ROUNDS), .ITER_W(ITER_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .finish(finish), .busy(busy), .error(error),
    .RC_start(RC_start), .RE_start(RE_start), .PE_start(PE_start),
    .RO_start(RO_start), .CP_start(CP_start),
    .RC_finish(fin[0]), .RE_finish(fin[1]), .PE_finish(fin[2]),
    .RO_finish(fin[3]), .CP_finish(fin[4]),
    .iteration(iteration)
  );

  assign starts = {CP_start, RO_start, PE_start, RE_start, RC_start};

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       start;
    logic [4:0] fin;
  } stim_t;

  typedef struct packed {
    logic              busy;
    logic              finish;
    logic              error;
    logic [4:0]        starts;
    logic [ITER_W-1:0] iter;
  } obs_t;

  stim_t stim_q[$];
  obs_t  exp_q[$];
  bit    model_err  = 1'b0;
  int    model_iter = 0;

  function automatic obs_t sample();
    obs_t o;
    o.busy   = busy;
    o.finish = finish;
    o.error  = error;
    o.starts = starts;
    o.iter   = iteration;
    return o;
  endfunction

  function automatic logic rand_start(input int mode);
    if (mode == 2) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  function automatic logic [4:0] rand_fin(input bit spur, input logic [4:0] mask);
    logic [4:0] r;
    r = 5'($urandom);
    return spur ? (r & mask) : 5'b0;
  endfunction

  task automatic push(input logic s, input logic [4:0] f, input logic b, input logic fn,
                      input logic e, input logic [4:0] st, input int it);
    stim_t sv;
    obs_t  ov;
    sv.start  = s;
    sv.fin    = f;
    ov.busy   = b;
    ov.finish = fn;
    ov.error  = e;
    ov.starts = st;
    ov.iter   = ITER_W'(it);
    stim_q.push_back(sv);
    exp_q.push_back(ov);
  endtask

  task automatic model_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 5'b0, 1'b0, 1'b0, model_err, 5'b0, model_iter);
  endtask

  // One decode request: latency L means the step's finish arrives in its L-th wait cycle.
  task automatic model_decode(input int lmin, input int lmax, input int re_lat,
                              input int hang_round, input int hang_step,
                              input int smode, input bit spur);
    int cur;
    int lat;
    logic [4:0] own;
    push(1'b1, rand_fin(spur, 5'h1f), 1'b0, 1'b0, model_err, 5'b0, model_iter);
    model_err = 1'b0;
    push(rand_start(smode), rand_fin(spur, 5'h1f), 1'b1, 1'b0, 1'b0, 5'b0, model_iter);
    cur = ROUNDS - 1;
    for (int r = 0; r < ROUNDS; r++) begin
      for (int j = 0; j < 5; j++) begin
        own = 5'b1 << j;
        lat = $urandom_range(lmax, lmin);
        if (j == 1 && re_lat > 0) lat = re_lat;
        if (r == hang_round && j == hang_step) lat = TIMEOUT + 1;
        push(rand_start(smode), rand_fin(spur, 5'h1f), 1'b1, 1'b0, 1'b0, own, cur);
        for (int k = 1; k <= lat && k <= TIMEOUT; k++) begin
          if (k == lat)
            push(rand_start(smode), rand_fin(spur, ~own) | own, 1'b1, 1'b0, 1'b0, 5'b0, cur);
          else
            push(rand_start(smode), rand_fin(spur, ~own), 1'b1, 1'b0, 1'b0, 5'b0, cur);
        end
        if (lat > TIMEOUT) begin
          model_err  = 1'b1;
          model_iter = cur;
          return;
        end
      end
      push(rand_start(smode), rand_fin(spur, 5'h1f), 1'b1, 1'b0, 1'b0, 5'b0, cur);
      if (cur > 0) cur--;
    end
    push(rand_start(smode), rand_fin(spur, 5'h1f), 1'b1, 1'b1, 1'b0, 5'b0, 0);
    model_iter = 0;
  endtask

  // Replays the schedule: check cycle c's outputs, then apply cycle c's inputs.
  task automatic replay(input string name, input int limit, output int fin_cycle, output int n_starts);
    obs_t o;
    fin_cycle = -1;
    n_starts  = 0;
    for (int c = 0; c < exp_q.size() && c < limit; c++) begin
      @(posedge clk);
      #1;
      o = sample();
      checks++;
      if (o !== exp_q[c]) begin
        errors++;
        $display("FAIL %s cycle %0d: got busy=%b finish=%b error=%b starts=%b iter=%0d, expected busy=%b finish=%b error=%b starts=%b iter=%0d",
                 name, c, o.busy, o.finish, o.error, o.starts, o.iter,
                 exp_q[c].busy, exp_q[c].finish, exp_q[c].error, exp_q[c].starts, exp_q[c].iter);
      end
      if (finish === 1'b1 && fin_cycle < 0) fin_cycle = c;
      n_starts += $countones(starts);
      start = stim_q[c].start;
      fin   = stim_q[c].fin;
    end
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic check_zero(input string name);
    obs_t o;
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL %s: got busy=%b finish=%b error=%b starts=%b iter=%0d, expected all zero",
               name, o.busy, o.finish, o.error, o.starts, o.iter);
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    fin   = 5'h1f;
    repeat (2) @(posedge clk);
    #1 check_zero("reset_held");
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    fin   = '0;
    @(posedge clk);
    #1 check_zero("reset_release");
    model_err  = 1'b0;
    model_iter = 0;
  endtask

  task automatic test_nominal();
    int fc, ns;
    model_decode(1, 1, 0, -1, -1, 0, 1'b0);
    model_idle(3);
    replay("nominal", 1 << 30, fc, ns);
    check_int("nominal_finish_cycle", fc, 266);
    check_int("nominal_step_pulses", ns, 5 * ROUNDS);
  endtask

  task automatic test_re_delay();
    int fc, ns;
    model_decode(1, 1, 7, -1, -1, 0, 1'b0);
    model_idle(3);
    replay("re_delay", 1 << 30, fc, ns);
    check_int("re_delay_finish_cycle", fc, 266 + ROUNDS * 6);
    check_int("re_delay_step_pulses", ns, 5 * ROUNDS);
  endtask

  task automatic test_spurious();
    int fc, ns;
    model_decode(1, 1, 0, -1, -1, 1, 1'b1);
    model_idle(3);
    replay("spurious", 1 << 30, fc, ns);
    check_int("spurious_finish_cycle", fc, 266);
  endtask

  task automatic test_watchdog();
    int fc, ns;
    // PE of round 1 never finishes: abort after TIMEOUT wait cycles, then a clean decode.
    model_decode(1, 1, 0, 0, 2, 0, 1'b0);
    model_idle(3);
    model_decode(1, 1, 0, -1, -1, 0, 1'b0);
    model_idle(3);
    replay("watchdog", 1 << 30, fc, ns);
    check_int("watchdog_finish_cycle", fc, 7 + TIMEOUT + 3 + 266);
  endtask

  task automatic test_watchdog_boundary();
    int fc, ns;
    model_decode(TIMEOUT, TIMEOUT, 0, -1, -1, 0, 1'b0);
    model_idle(2);
    replay("watchdog_boundary", 1 << 30, fc, ns);
    check_int("boundary_finish_cycle", fc, 2 + ROUNDS * (5 * (TIMEOUT + 1) + 1));
  endtask

  task automatic test_random();
    int fc, ns, hr, hs;
    for (int n = 0; n < 4; n++) begin
      hr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, ROUNDS - 1)) : -1;
      hs = $urandom_range(0, 4);
      model_decode(1, TIMEOUT, 0, hr, hs, 1, 1'b1);
      model_idle($urandom_range(1, 3));
    end
    replay("random", 1 << 30, fc, ns);
  endtask

  task automatic test_back_to_back();
    int fc, ns;
    model_decode(1, 1, 0, -1, -1, 2, 1'b0);
    model_decode(1, 1, 0, -1, -1, 2, 1'b0);
    model_idle(3);
    replay("back_to_back", 1 << 30, fc, ns);
    check_int("b2b_first_finish_cycle", fc, 266);
    check_int("b2b_step_pulses", ns, 2 * 5 * ROUNDS);
  endtask

  task automatic test_async_reset();
    int fc, ns;
    model_decode(1, 1, 0, -1, -1, 0, 1'b0);
    // Cycle 108 is RO_CAL of round 10.
    replay("pre_reset", 109, fc, ns);
    #2 rst = 1'b0;
    #1 check_zero("async_reset_immediate");
    start = 1'b0;
    fin   = '0;
    @(posedge clk);
    #1 check_zero("async_reset_held");
    @(negedge clk);
    rst        = 1'b1;
    model_err  = 1'b0;
    model_iter = 0;
    model_decode(1, 1, 0, -1, -1, 0, 1'b0);
    model_idle(3);
    replay("post_reset", 1 << 30, fc, ns);
    check_int("post_reset_finish_cycle", fc, 266);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_re_delay();
    test_spurious();
    test_watchdog();
    test_watchdog_boundary();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
